// File: rtl/gray_link_pkg.sv
// Shared types and default parameters for the Gray-to-binary link scheduler.
package gray_link_pkg;

    localparam int WIDTH_DEF   = 5;
    localparam int CAP_LAT_DEF = 6;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } inflight_t;

endpackage

// File: rtl/gray_link_sched_if.sv
// Handshake/datapath bundle between the requesters, the serial link and the scheduler.
// The scheduler uses the slave modport; the surrounding environment uses master.
interface gray_link_sched_if #(
    parameter int WIDTH = gray_link_pkg::WIDTH_DEF
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             dp_shift;
    logic [WIDTH-1:0] dp_word;
    logic [WIDTH-1:0] dp_par_out;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, dp_par_out,
        output req0_ready, req1_ready, dp_shift, dp_word,
               res_valid, res_data, res_id, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, dp_par_out,
        input  req0_ready, req1_ready, dp_shift, dp_word,
               res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/gray_link_arb.sv
// Two-way arbiter for the link scheduler.
// GRAY_LINK_RR_EN defined: round-robin on ties via pointer r_rr.
// GRAY_LINK_RR_EN undefined: fixed priority, requester 0 wins ties, no pointer state.
module gray_link_arb
    import gray_link_pkg::*;
(
`ifdef GRAY_LINK_RR_EN
    input  logic    clk,
    input  logic    rst_n,
`endif
    input  logic    i_en,
    input  logic    i_v0,
    input  logic    i_v1,
    output logic    o_gnt0,
    output logic    o_gnt1,
    output req_id_t o_id
);

`ifdef GRAY_LINK_RR_EN
    logic r_rr;

    // Grant decode: on a tie the pointer names the winner
    always_comb begin
        o_gnt0 = i_en & i_v0 & (~i_v1 | ~r_rr);
        o_gnt1 = i_en & i_v1 & (~i_v0 |  r_rr);
        o_id   = o_gnt1;
    end

    // After any grant, point at the requester that did not win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 1'b0;
        end else if (o_gnt0 | o_gnt1) begin
            r_rr <= o_gnt0;
        end
    end
`else
    // Grant decode: requester 0 always wins a tie
    always_comb begin
        o_gnt0 = i_en & i_v0;
        o_gnt1 = i_en & i_v1 & ~i_v0;
        o_id   = o_gnt1;
    end
`endif

endmodule

// File: rtl/gray_link_sched.sv
// Scheduler for the serial Gray-to-binary link: frame-aligned PISO loads,
// two-requester arbitration and fixed-latency result capture tagged by requester.
// Optional feature macro: GRAY_LINK_RR_EN (round-robin arbitration, see gray_link_arb).
module gray_link_sched
    import gray_link_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CAP_LAT = CAP_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_link_sched_if.slave   lnk
);

    localparam int PH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PH_W-1:0]  r_ph;
    logic             r_warm;
    inflight_t        r_dly [CAP_LAT];
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    req_id_t          r_res_id;

    logic             w_en;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_grant;
    req_id_t          w_id;
    inflight_t        w_push;
    inflight_t        w_exit;
    logic             w_busy;

    // Frame phase counter; the first frame after reset is a warm-up with no grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph   <= '0;
            r_warm <= 1'b1;
        end else if (r_ph == PH_W'(WIDTH - 1)) begin
            r_ph   <= '0;
            r_warm <= 1'b0;
        end else begin
            r_ph   <= r_ph + PH_W'(1);
        end
    end

    assign w_en = (r_ph == '0) && !r_warm;

    gray_link_arb u_arb (
`ifdef GRAY_LINK_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .i_en   (w_en),
        .i_v0   (lnk.req0_valid),
        .i_v1   (lnk.req1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1),
        .o_id   (w_id)
    );

    assign w_grant        = w_gnt0 | w_gnt1;
    assign lnk.req0_ready = w_gnt0;
    assign lnk.req1_ready = w_gnt1;
    assign lnk.dp_shift   = ~w_grant;
    assign lnk.dp_word    = w_gnt0 ? lnk.req0_data :
                            w_gnt1 ? lnk.req1_data : '0;

    assign w_push.valid = w_grant;
    assign w_push.id    = w_id;
    assign w_exit       = r_dly[CAP_LAT-1];

    // In-flight delay line: the load edge pushes {1,id}, every other edge pushes a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CAP_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= w_push;
            for (int i = 1; i < CAP_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Capture the link output as the owning entry leaves the delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
        end else begin
            r_res_valid <= w_exit.valid;
            if (w_exit.valid) begin
                r_res_data <= lnk.dp_par_out;
                r_res_id   <= w_exit.id;
            end
        end
    end

    // Busy while any delay-line slot holds a word
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < CAP_LAT; i++) begin
            w_busy = w_busy | r_dly[i].valid;
        end
    end

    assign lnk.res_valid = r_res_valid;
    assign lnk.res_data  = r_res_data;
    assign lnk.res_id    = r_res_id;
    assign lnk.busy      = w_busy;

endmodule

// File: tb/tb_gray_link_sched.sv
// Directed bench for gray_link_sched. The serial link is modelled as
// dp_par_out = gray2bin(word loaded CAP_LAT edges earlier).
module tb_gray_link_sched;
    import gray_link_pkg::*;

    localparam int W  = 5;
    localparam int CL = 6;
`ifdef GRAY_LINK_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_link_sched_if #(.WIDTH(W)) lnk ();

    gray_link_sched #(.WIDTH(W), .CAP_LAT(CL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lnk   (lnk)
    );

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [W-1:0] hist [CL];
    always @(posedge clk) begin
        hist[0] <= lnk.dp_shift ? '0 : lnk.dp_word;
        for (int i = 1; i < CL; i++) hist[i] <= hist[i-1];
    end
    assign lnk.dp_par_out = gray2bin(hist[CL-1]);

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (cyc %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int k;
        bit id;
        lnk.req0_valid = 1'b0;
        lnk.req0_data  = '0;
        lnk.req1_valid = 1'b0;
        lnk.req1_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, with requester 0 already asking
        lnk.req0_valid = 1'b1;
        lnk.req0_data  = 5'b10110;
        #1;
        chk("rst_res_valid", lnk.res_valid, 0);
        chk("rst_res_data",  lnk.res_data,  0);
        chk("rst_res_id",    lnk.res_id,    0);
        chk("rst_busy",      lnk.busy,      0);
        chk("rst_dp_shift",  lnk.dp_shift,  1);
        chk("rst_dp_word",   lnk.dp_word,   0);
        chk("rst_ready0",    lnk.req0_ready, 0);
        chk("rst_ready1",    lnk.req1_ready, 0);

        // Test 1: single word, warm-up then grant at second frame
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            chk("t1_warm_ready0", lnk.req0_ready, 0);
            chk("t1_warm_shift",  lnk.dp_shift,   1);
        end
        tick();
        chk("t1_ready0", lnk.req0_ready, 1);
        chk("t1_shift",  lnk.dp_shift,   0);
        chk("t1_word",   lnk.dp_word,    5'b10110);
        tick();
        lnk.req0_valid = 1'b0;
        #1;
        chk("t1_busy",      lnk.busy,      1);
        chk("t1_res_early", lnk.res_valid, 0);
        for (int c = 7; c <= 11; c++) begin
            tick();
            chk("t1_res_early", lnk.res_valid, 0);
        end
        tick();
        chk("t1_res_valid", lnk.res_valid, 1);
        chk("t1_res_data",  lnk.res_data,  5'b11011);
        chk("t1_res_id",    lnk.res_id,    0);
        chk("t1_busy_done", lnk.busy,      0);
        tick();
        chk("t1_res_pulse", lnk.res_valid, 0);
        chk("t1_res_hold",  lnk.res_data,  5'b11011);

        // Test 2: both requesters continuously valid
        rst_n = 1'b0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        lnk.req0_valid = 1'b1;
        lnk.req0_data  = 5'b00001;
        lnk.req1_valid = 1'b1;
        lnk.req1_data  = 5'b00011;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (cyc == 21) begin
                lnk.req0_valid = 1'b0;
                lnk.req1_valid = 1'b0;
                #1;
            end
            if (cyc >= 5 && cyc <= 20 && (cyc % 5) == 0) begin
                k  = (cyc - 5) / 5;
                id = RR ? k[0] : 1'b0;
                chk("t2_ready0", lnk.req0_ready, !id);
                chk("t2_ready1", lnk.req1_ready, id);
                chk("t2_shift",  lnk.dp_shift,   0);
            end else begin
                chk("t2_idle_ready0", lnk.req0_ready, 0);
                chk("t2_idle_ready1", lnk.req1_ready, 0);
                chk("t2_idle_shift",  lnk.dp_shift,   1);
            end
            if (cyc >= 12 && cyc <= 27 && ((cyc - 12) % 5) == 0) begin
                k  = (cyc - 12) / 5;
                id = RR ? k[0] : 1'b0;
                chk("t2_res_valid", lnk.res_valid, 1);
                chk("t2_res_id",    lnk.res_id,    id);
                chk("t2_res_data",  lnk.res_data,  id ? 5'b00010 : 5'b00001);
            end else begin
                chk("t2_res_quiet", lnk.res_valid, 0);
            end
        end

        // Test 3: requester 1 raised at ph==2 waits for the boundary
        while (cyc < 32) tick();
        lnk.req1_valid = 1'b1;
        lnk.req1_data  = 5'b11000;
        #1;
        for (int c = 32; c <= 34; c++) begin
            if (c > 32) tick();
            chk("t3_wait_ready1", lnk.req1_ready, 0);
            chk("t3_wait_shift",  lnk.dp_shift,   1);
        end
        tick();
        chk("t3_ready1", lnk.req1_ready, 1);
        chk("t3_ready0", lnk.req0_ready, 0);
        chk("t3_shift",  lnk.dp_shift,   0);
        chk("t3_word",   lnk.dp_word,    5'b11000);
        for (int c = 36; c <= 41; c++) begin
            tick();
            if (c == 36) begin
                lnk.req1_valid = 1'b0;
                #1;
            end
            chk("t3_after_shift", lnk.dp_shift,  1);
            chk("t3_res_early",   lnk.res_valid, 0);
        end
        tick();
        chk("t3_res_valid", lnk.res_valid, 1);
        chk("t3_res_id",    lnk.res_id,    1);
        chk("t3_res_data",  lnk.res_data,  5'b10000);

        // Test 5: two back-to-back grants, then reset before either result
        tick();
        lnk.req0_valid = 1'b1;
        lnk.req0_data  = 5'b00111;
        for (int c = 44; c <= 50; c++) begin
            tick();
            if (c == 45 || c == 50) chk("t5_ready0", lnk.req0_ready, 1);
        end
        tick();
        lnk.req0_valid = 1'b0;
        #1;
        chk("t5_busy_before", lnk.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy",      lnk.busy,       0);
        chk("t5_res_valid", lnk.res_valid,  0);
        chk("t5_res_data",  lnk.res_data,   0);
        chk("t5_res_id",    lnk.res_id,     0);
        chk("t5_shift",     lnk.dp_shift,   1);
        chk("t5_word",      lnk.dp_word,    0);
        chk("t5_ready0",    lnk.req0_ready, 0);
        chk("t5_ready1",    lnk.req1_ready, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t5_rst_res_valid", lnk.res_valid, 0);
            chk("t5_rst_busy",      lnk.busy,      0);
        end

        // Test 6: idle for 20 cycles after reset release
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t6_shift",     lnk.dp_shift,  1);
            chk("t6_res_valid", lnk.res_valid, 0);
            chk("t6_busy",      lnk.busy,      0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
